// File: rtl/led_ctrl_pkg.sv
// ============================================================================
// Module   : led_ctrl_pkg
// Purpose  : Shared types and constants for the LED mode controller: FSM
//            state encoding, mode indices and bus widths.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package led_ctrl_pkg;

  localparam int unsigned MODE_COUNT = 4;
  localparam int unsigned MODE_W     = 2;
  localparam int unsigned LED_W      = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    SWITCH = 2'd2
  } state_e;

  localparam logic [MODE_W-1:0] MODE0 = 2'd0;
  localparam logic [MODE_W-1:0] MODE1 = 2'd1;
  localparam logic [MODE_W-1:0] MODE2 = 2'd2;
  localparam logic [MODE_W-1:0] MODE3 = 2'd3;

  // One-hot restart vector addressed to the processor of mode m.
  function automatic logic [MODE_COUNT-1:0] mode_onehot(input logic [MODE_W-1:0] m);
    return 4'b0001 << m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_mode_controller_if.sv
// ============================================================================
// Module   : led_mode_controller_if
// Purpose  : Button, pattern and control signals between the LED mode
//            controller (slave) and its environment (master).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface led_mode_controller_if;
  import led_ctrl_pkg::*;

  logic                  btn_mode;
  logic                  btn_pause;
  logic [LED_W-1:0]      leds_in0;
  logic [LED_W-1:0]      leds_in1;
  logic [LED_W-1:0]      leds_in2;
  logic [LED_W-1:0]      leds_in3;
  logic                  tick;
  logic                  pause;
  logic [MODE_W-1:0]     mode;
  logic [MODE_COUNT-1:0] mode_rst;
  logic [LED_W-1:0]      leds;

  modport master (
    output btn_mode, btn_pause, leds_in0, leds_in1, leds_in2, leds_in3,
    input  tick, pause, mode, mode_rst, leds
  );

  modport slave (
    input  btn_mode, btn_pause, leds_in0, leds_in1, leds_in2, leds_in3,
    output tick, pause, mode, mode_rst, leds
  );

endinterface

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Divides clk into a one-cycle tick every TICK_DIV counted cycles.
//            'run' advances the count, 'clear' zeroes it, otherwise it holds.
//            Both controls refer to the cycle being entered, so the count and
//            the registered tick line up with the controller state register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic run,
  input  wire logic clear,
  output logic      tick
);

  localparam int unsigned      CNT_W   = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // Next count; tick is raised for the cycle in which the count sits at its top.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = (count_q == CNT_MAX) ? '0 : count_q + CNT_W'(1);
      tick_d  = (count_d == CNT_MAX);
    end
  end

  // Count and tick registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/led_mode_controller.sv
// ============================================================================
// Module   : led_mode_controller
// Purpose  : Selects one of four LED pattern processors, issues their step
//            tick, pause level and one-hot restart pulse on mode entry.
//            Optional macro LED_MODE_AUTO_CYCLE_EN: advance the mode
//            automatically after AUTO_TICKS ticks spent running in a mode.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module led_mode_controller
  import led_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned AUTO_TICKS = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  led_mode_controller_if.slave  bus
);

  // An illegal configuration parks the prescaler instead of emitting a
  // malformed tick stream.
  localparam bit PARAMS_LEGAL = (TICK_DIV >= 2) && (AUTO_TICKS >= 1);

  state_e                state_q, state_d;
  logic [MODE_W-1:0]     mode_q, mode_d;
  logic [MODE_COUNT-1:0] mode_rst_q, mode_rst_d;
  logic                  pause_q, pause_d;
  logic [LED_W-1:0]      leds_q, leds_d;

  logic                  tick_w;
  logic                  auto_hit;
  logic                  advance;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   ((state_d == RUN) && PARAMS_LEGAL),
    .clear (state_d == SWITCH),
    .tick  (tick_w)
  );

`ifdef LED_MODE_AUTO_CYCLE_EN
  localparam int unsigned     TC_W    = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS) : 1;
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(AUTO_TICKS - 1);

  logic [TC_W-1:0] tick_cnt_q, tick_cnt_d;

  // The AUTO_TICKS-th tick (tick is only ever high in RUN) requests a switch.
  always_comb begin
    auto_hit = tick_w && (tick_cnt_q == TC_LAST);
  end

  // Ticks spent in the current mode; any mode change restarts the count.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (state_d == SWITCH) begin
      tick_cnt_d = '0;
    end else if (tick_w) begin
      tick_cnt_d = tick_cnt_q + TC_W'(1);
    end
  end

  // Tick counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end
`else
  // Without auto-cycling the mode only moves on btn_mode.
  always_comb begin
    auto_hit = 1'b0;
  end
`endif

  // An auto-advance and a button press in the same cycle merge into one step.
  assign advance = bus.btn_mode || auto_hit;

  // Next-state and output decode; mode requests beat pause requests and all
  // buttons are dropped during the single SWITCH cycle.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    mode_rst_d = '0;
    case (state_q)
      RUN, PAUSED: begin
        if (advance) begin
          state_d    = SWITCH;
          mode_d     = mode_q + MODE_W'(1);
          mode_rst_d = mode_onehot(mode_d);
        end else if (bus.btn_pause) begin
          state_d = (state_q == RUN) ? PAUSED : RUN;
        end
      end
      SWITCH:  state_d = RUN;
      default: state_d = RUN;
    endcase
    pause_d = (state_d == PAUSED);
    case (mode_q)
      MODE0:   leds_d = bus.leds_in0;
      MODE1:   leds_d = bus.leds_in1;
      MODE2:   leds_d = bus.leds_in2;
      default: leds_d = bus.leds_in3;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      mode_q     <= MODE0;
      mode_rst_q <= mode_onehot(MODE0);
      pause_q    <= 1'b0;
      leds_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      mode_rst_q <= mode_rst_d;
      pause_q    <= pause_d;
      leds_q     <= leds_d;
    end
  end

  assign bus.tick     = tick_w;
  assign bus.pause    = pause_q;
  assign bus.mode     = mode_q;
  assign bus.mode_rst = mode_rst_q;
  assign bus.leds     = leds_q;

endmodule

`default_nettype wire

// File: tb/tb_led_mode_controller.sv
// ============================================================================
// Module   : tb_led_mode_controller
// Purpose  : Directed self-checking bench for led_mode_controller with
//            TICK_DIV=4, AUTO_TICKS=3. Builds with LED_MODE_AUTO_CYCLE_EN
//            defined run the auto-advance sequence instead of the manual one.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_mode_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] exp_leds [4];

  led_mode_controller_if bus_if ();

  led_mode_controller #(
    .TICK_DIV   (4),
    .AUTO_TICKS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b1;
    bus_if.btn_mode  = 1'b0;
    bus_if.btn_pause = 1'b0;
    bus_if.leds_in0  = 8'h11;
    bus_if.leds_in1  = 8'h22;
    bus_if.leds_in2  = 8'h33;
    bus_if.leds_in3  = 8'h44;
    exp_leds[0] = 8'h11;
    exp_leds[1] = 8'h22;
    exp_leds[2] = 8'h33;
    exp_leds[3] = 8'h44;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mode", bus_if.mode, 0);
    chk("rst_pause", bus_if.pause, 0);
    chk("rst_tick", bus_if.tick, 0);
    chk("rst_mode_rst", bus_if.mode_rst, 4'b0001);
    chk("rst_leds", bus_if.leds, 0);
    reset = 1'b0;

`ifndef LED_MODE_AUTO_CYCLE_EN
    // Idle run: tick on the 3rd, 7th, 11th clock after release.
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("idle_tick", bus_if.tick, (k % 4 == 3) ? 1 : 0);
      if (k == 1) begin
        chk("idle_mode_rst_clear", bus_if.mode_rst, 0);
        chk("idle_leds_mode0", bus_if.leds, 8'h11);
      end
    end
    chk("idle_mode", bus_if.mode, 0);
    chk("idle_pause", bus_if.pause, 0);

    // Pause with prescaler at 1, hold for 10 cycles, resume.
    step();
    bus_if.btn_pause = 1'b1;
    step();
    bus_if.btn_pause = 1'b0;
    chk("pause_set", bus_if.pause, 1);
    chk("pause_tick0", bus_if.tick, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("paused_tick", bus_if.tick, 0);
      chk("paused_level", bus_if.pause, 1);
    end
    bus_if.btn_pause = 1'b1;
    step();
    bus_if.btn_pause = 1'b0;
    chk("resume_pause", bus_if.pause, 0);
    chk("resume_tick_c1", bus_if.tick, 0);
    step();
    chk("resume_tick_c2", bus_if.tick, 1);
    step();
    chk("resume_tick_c3", bus_if.tick, 0);

    // Four mode presses spaced six cycles apart.
    for (int i = 0; i < 4; i++) begin
      bus_if.btn_mode = 1'b1;
      step();
      bus_if.btn_mode = 1'b0;
      chk("sw_mode", bus_if.mode, (i + 1) % 4);
      chk("sw_mode_rst", bus_if.mode_rst, 1 << ((i + 1) % 4));
      chk("sw_tick", bus_if.tick, 0);
      step();
      chk("sw_mode_rst_clear", bus_if.mode_rst, 0);
      chk("sw_leds", bus_if.leds, exp_leds[(i + 1) % 4]);
      repeat (4) step();
    end

    // Both buttons together: mode wins; buttons in SWITCH ignored.
    bus_if.btn_mode  = 1'b1;
    bus_if.btn_pause = 1'b1;
    step();
    chk("both_mode", bus_if.mode, 1);
    chk("both_pause", bus_if.pause, 0);
    chk("both_mode_rst", bus_if.mode_rst, 4'b0010);
    step();
    bus_if.btn_mode  = 1'b0;
    bus_if.btn_pause = 1'b0;
    chk("sw_ignore_mode", bus_if.mode, 1);
    chk("sw_ignore_pause", bus_if.pause, 0);
    chk("sw_ignore_mode_rst", bus_if.mode_rst, 0);

    // Mode press from PAUSED clears pause.
    bus_if.btn_pause = 1'b1;
    step();
    bus_if.btn_pause = 1'b0;
    chk("p2s_paused", bus_if.pause, 1);
    bus_if.btn_mode = 1'b1;
    step();
    bus_if.btn_mode = 1'b0;
    chk("p2s_pause", bus_if.pause, 0);
    chk("p2s_mode", bus_if.mode, 2);
    chk("p2s_mode_rst", bus_if.mode_rst, 4'b0100);
    step();
    chk("p2s_run_pause", bus_if.pause, 0);

    // Pattern pass-through with one-cycle latency in mode 2.
    bus_if.leds_in2 = 8'hAA;
    #1;
    chk("leds_latency_aa", bus_if.leds, 8'h33);
    step();
    chk("leds_aa", bus_if.leds, 8'hAA);
    bus_if.leds_in2 = 8'h55;
    #1;
    chk("leds_latency_55", bus_if.leds, 8'hAA);
    step();
    chk("leds_55", bus_if.leds, 8'h55);

    // Asynchronous reset while paused.
    bus_if.btn_pause = 1'b1;
    step();
    bus_if.btn_pause = 1'b0;
    chk("rp_paused", bus_if.pause, 1);
    #3 reset = 1'b1;
    #1;
    chk("rp_pause", bus_if.pause, 0);
    chk("rp_mode", bus_if.mode, 0);
    chk("rp_mode_rst", bus_if.mode_rst, 4'b0001);
    chk("rp_leds", bus_if.leds, 0);
    chk("rp_tick", bus_if.tick, 0);
    step();
    reset = 1'b0;

    // Asynchronous reset during SWITCH.
    bus_if.btn_mode = 1'b1;
    step();
    bus_if.btn_mode = 1'b0;
    chk("rs_in_switch", bus_if.mode, 1);
    #3 reset = 1'b1;
    #1;
    chk("rs_mode", bus_if.mode, 0);
    chk("rs_mode_rst", bus_if.mode_rst, 4'b0001);
    step();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("rs_tick", bus_if.tick, (k == 3) ? 1 : 0);
    end
`else
    // Auto advance after three ticks (ticks at clocks 3, 7, 11).
    repeat (11) step();
    chk("auto_tick3", bus_if.tick, 1);
    chk("auto_before", bus_if.mode, 0);
    step();
    chk("auto_mode1", bus_if.mode, 1);
    chk("auto_mode_rst1", bus_if.mode_rst, 4'b0010);
    repeat (7) step();
    chk("auto_tick2", bus_if.tick, 1);
    step();
    bus_if.btn_pause = 1'b1;
    step();
    bus_if.btn_pause = 1'b0;
    chk("auto_paused", bus_if.pause, 1);
    repeat (4) step();
    chk("auto_held", bus_if.mode, 1);
    bus_if.btn_pause = 1'b1;
    step();
    bus_if.btn_pause = 1'b0;
    step();
    step();
    chk("auto_tick3_late", bus_if.tick, 1);
    chk("auto_still1", bus_if.mode, 1);
    step();
    chk("auto_mode2", bus_if.mode, 2);
    chk("auto_mode_rst2", bus_if.mode_rst, 4'b0100);

    // Auto advance coinciding with btn_mode steps once.
    repeat (11) step();
    chk("coin_tick", bus_if.tick, 1);
    bus_if.btn_mode = 1'b1;
    step();
    bus_if.btn_mode = 1'b0;
    chk("coin_mode", bus_if.mode, 3);
    chk("coin_mode_rst", bus_if.mode_rst, 4'b1000);
    step();
    chk("coin_mode_after", bus_if.mode, 3);
    chk("coin_mode_rst_clear", bus_if.mode_rst, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_mode_controller.md
LED_MODE_CONTROLLER -- requirements
Module: led_mode_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per pattern tick (legal >= 2).
REQ-002 SHALL have parameter AUTO_TICKS, default 32, ticks per mode before auto-advance (used only under AUTO_CYCLE_EN; legal >= 1).
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_mode  input  1  one-cycle pulse, already debounced/synchronised; request next mode.
REQ-006 SHALL have port btn_pause  input  1  one-cycle pulse; toggle pause.
REQ-007 SHALL have ports leds_in0..leds_in3  input  8 each  pattern from mode processors 0..3.
REQ-008 SHALL have port tick  output  1  one-cycle step strobe to all mode processors.
REQ-009 SHALL have port pause  output  1  high while paused; drives processor pause inputs.
REQ-010 SHALL have port mode  output  2  current mode index.
REQ-011 SHALL have port mode_rst  output  4  one-hot, one-cycle restart pulse to the processor being entered.
REQ-012 SHALL have port leds  output  8  registered pattern of selected processor.

Function
REQ-013 SHALL implement FSM states RUN, PAUSED, SWITCH; all outputs registered.
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 in RUN, assert tick for exactly one cycle when count = TICK_DIV-1, then wrap to 0.
REQ-015 Prescaler SHALL hold its value in PAUSED (resume continues the interrupted period) and SHALL clear to 0 in SWITCH; tick SHALL never assert outside RUN.
REQ-016 RUN + btn_pause -> PAUSED; PAUSED + btn_pause -> RUN; pause output = 1 exactly while state is PAUSED.
REQ-017 RUN or PAUSED + btn_mode -> SWITCH: mode <= mode+1 modulo 4 (3 wraps to 0), mode_rst <= one-hot of new mode for that single SWITCH cycle.
REQ-018 SWITCH SHALL last exactly one cycle, then go to RUN unconditionally (mode change clears pause).
REQ-019 btn_mode and btn_pause in same cycle: btn_mode wins, btn_pause discarded.
REQ-020 Buttons arriving while in SWITCH SHALL be ignored.
REQ-021 leds SHALL equal leds_in[mode] with one-cycle latency, sampled every cycle in all states.

Reset
REQ-022 On reset: state RUN, mode 0, prescaler 0, tick 0, pause 0, mode_rst 4'b0001, leds 0; mode_rst returns to 0 on the first clock after reset release.
REQ-023 Reset asserted mid-SWITCH or mid-pause SHALL override everything and yield REQ-022 values immediately.

Configuration
REQ-024 Macro LED_MODE_AUTO_CYCLE_EN defined: tick counter counts ticks issued in RUN, holds in PAUSED, clears on any mode change; at AUTO_TICKS-th tick the block performs the REQ-017 transition on the next cycle.
REQ-025 Auto-advance coinciding with btn_mode SHALL advance mode exactly once.
REQ-026 Macro undefined: no tick counter logic; mode changes only via btn_mode; AUTO_TICKS ignored.

Structure
REQ-027 Package led_ctrl_pkg SHALL hold state encoding (RUN/PAUSED/SWITCH), mode constants MODE0..MODE3, and mode count 4.
REQ-028 Prescaler SHALL be sub-module tick_prescaler (inputs clk, reset, run, clear; output tick); remaining logic in top.

Verification (TICK_DIV=4, AUTO_TICKS=3)
REQ-029 Release reset, idle 12 cycles -> mode_rst=0001 for 1 cycle, tick pulses every 4th cycle, mode=0, pause=0.
REQ-030 btn_pause after 2 prescaler counts, wait 10 cycles, btn_pause -> no tick while paused; first tick 2 cycles after resume.
REQ-031 Four btn_mode pulses spaced 6 cycles -> mode 1,2,3,0; mode_rst 0010,0100,1000,0001; no tick in each SWITCH cycle.
REQ-032 btn_mode and btn_pause same cycle while RUN -> mode increments, pause stays 0; btn_pause during SWITCH ignored.
REQ-033 leds_in2=8'hAA, mode=2 -> leds=8'hAA one cycle later; change leds_in2 to 8'h55 -> leds follows after one cycle.
REQ-034 With LED_MODE_AUTO_CYCLE_EN: 3 ticks in RUN -> mode advances once; pause between ticks 2 and 3 delays advance accordingly.
